// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, controller states and
// the result-flag helper used by both the single-cycle and multiply paths.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_CMP = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
    logic c;
    logic v;
  } flags_t;

  // n/z/p derive purely from the result; c/v come from the operation.
  function automatic flags_t make_flags(input logic msb, input logic is_zero,
                                        input logic carry, input logic ovf);
    flags_t f;
    f.n = msb;
    f.z = is_zero;
    f.p = ~msb & ~is_zero;
    f.c = carry;
    f.v = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// The first step happens on the start edge, so the product is ready WIDTH edges later.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] src_mcand;
  logic [WIDTH-1:0] src_mplier;
  logic [WIDTH-1:0] src_acc;
  logic [WIDTH-1:0] acc_step;

  always_comb begin
    src_mcand  = start ? a : mcand_q;
    src_mplier = start ? b : mplier_q;
    src_acc    = start ? '0 : acc_q;
    acc_step   = src_acc + (src_mplier[0] ? src_mcand : '0);
  end

  // cnt counts completed steps; the step taken while cnt==WIDTH-1 is the last.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = src_mcand << 1;
      mplier_d = src_mplier >> 1;
      acc_d    = acc_step;
      cnt_d    = CW'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      mcand_d  = src_mcand << 1;
      mplier_d = src_mplier >> 1;
      acc_d    = acc_step;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product = acc_step;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith ops,
// an optional iterative multiplier, and registered result/flags.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             p,
  output logic             c,
  output logic             v,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;
  localparam int SW  = $clog2(WIDTH);

  state_e state_q, state_d;

  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             is_mul;
  logic             op_legal;
  logic             load_alu;
  logic             load_mul;

  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign accept   = in_valid && in_ready;
  assign is_mul   = (alu_op == OP_MUL) && (MUL_EN != 0);
  assign op_legal = (alu_op <= OP_SHR) || is_mul;

  // Single-cycle datapath, feeding the output register directly.
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL:  alu_res = a << shamt;
      OP_SHR:  alu_res = a >> shamt;
      default: alu_res = '0;
    endcase
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(
        .WIDTH(WIDTH)
      ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_mul),
        .a      (a),
        .b      (b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_product)
      );
    end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // Controller: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = is_mul ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (accept) begin
          state_d = is_mul ? ST_BUSY : ST_DONE;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller: outputs. In DONE a new op is taken only when the result is consumed.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = ~rst;
      ST_BUSY: load_mul = mul_busy && mul_done;
      ST_DONE: begin
        in_ready  = ~rst && out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
    load_alu = accept && !is_mul;
  end

  always_comb begin
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    if (load_alu) begin
      result_d  = alu_res;
      flags_d   = make_flags(alu_res[MSB], alu_res == '0, alu_c, alu_v);
      illegal_d = ~op_legal;
    end else if (load_mul) begin
      result_d  = mul_product;
      flags_d   = make_flags(mul_product[MSB], mul_product == '0, 1'b0, 1'b0);
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign result  = result_q;
  assign n       = flags_q.n;
  assign z       = flags_q.z;
  assign p       = flags_q.p;
  assign c       = flags_q.c;
  assign v       = flags_q.v;
  assign illegal = illegal_q;

endmodule
